// File: rtl/dcache_ctrl_wb.sv
// Direct-mapped write-back data cache controller: single-cycle hits, a miss FSM
// that writes back a dirty victim before filling, and a snoop search/invalidate port.
module dcache_ctrl_wb #(
  parameter  int ADDR_W  = 13,
  parameter  int DATA_W  = 16,
  parameter  int OFFS_W  = 2,
  parameter  int INDEX_W = 6,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFS_W,
  localparam int LINE_W  = DATA_W << OFFS_W,
  localparam int LINES   = 1 << INDEX_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_we,
  input  logic                       i_re,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_hit,
  output logic                       o_stall,
  output logic [ADDR_W-OFFS_W-1:0]   o_mem_addr,
  output logic [LINE_W-1:0]          o_mem_wr_data,
  output logic                       o_mem_we,
  output logic                       o_mem_re,
  input  logic [LINE_W-1:0]          i_mem_rd_data,
  input  logic                       i_mem_rdy,
  input  logic [ADDR_W-1:0]          i_snoop_addr,
  input  logic                       i_snoop_req,
  input  logic                       i_snoop_inv,
  output logic                       o_snoop_found,
  output logic                       o_snoop_dirty,
  output logic [TAG_W-1:0]           o_tag_out,
  output logic [1:0]                 o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WB      = 2'd1,
    S_FILL    = 2'd2,
    S_INSTALL = 2'd3
  } state_t;

  // Memory handshake: o_mem_we / o_mem_re are held with o_mem_addr and
  // o_mem_wr_data stable until a cycle where i_mem_rdy=1; that edge completes
  // the transfer (and captures i_mem_rd_data for a fill).

  state_t              r_state;
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [LINE_W-1:0]   r_data [LINES];
  logic [LINE_W-1:0]   r_fill_line;
  logic                r_mem_we;
  logic                r_mem_re;
  logic [ADDR_W-OFFS_W-1:0] r_mem_addr;
  logic [LINE_W-1:0]   r_mem_wr_data;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic [OFFS_W-1:0]   w_off;
  logic [TAG_W-1:0]    w_stag;
  logic [INDEX_W-1:0]  w_sidx;
  logic [LINE_W-1:0]   w_line;
  logic                w_req;
  logic                w_hit;
  logic                w_miss;
  logic                w_store_hit;
  logic                w_snoop_kill;
  logic                w_unused_soff;

  assign w_tag  = i_addr[ADDR_W-1 -: TAG_W];
  assign w_idx  = i_addr[OFFS_W +: INDEX_W];
  assign w_off  = i_addr[OFFS_W-1:0];
  assign w_stag = i_snoop_addr[ADDR_W-1 -: TAG_W];
  assign w_sidx = i_snoop_addr[OFFS_W +: INDEX_W];
  assign w_unused_soff = ^i_snoop_addr[OFFS_W-1:0];

  assign w_line      = r_data[w_idx];
  assign w_req       = i_we | i_re;
  assign w_hit       = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & (r_state == S_IDLE);
  assign w_miss      = w_req & ~w_hit & (r_state == S_IDLE);
  assign w_store_hit = w_hit & i_we;

  assign o_snoop_found = r_valid[w_sidx] & (r_tag[w_sidx] == w_stag);
  assign o_snoop_dirty = o_snoop_found & r_dirty[w_sidx];
  assign w_snoop_kill  = i_snoop_req & i_snoop_inv & o_snoop_found;

  assign o_rd_data     = w_line[int'(w_off)*DATA_W +: DATA_W];
  assign o_hit         = w_hit;
  assign o_stall       = (r_state == S_IDLE) ? (w_req & ~w_hit) : 1'b1;
  assign o_tag_out     = r_tag[w_idx];
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wr_data = r_mem_wr_data;
  assign o_mem_we      = r_mem_we;
  assign o_mem_re      = r_mem_re;
  assign o_state       = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_fill_line   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state       <= S_WB;
              r_mem_we      <= 1'b1;
              r_mem_addr    <= {r_tag[w_idx], w_idx};
              r_mem_wr_data <= w_line;
            end else begin
              r_state    <= S_FILL;
              r_mem_re   <= 1'b1;
              r_mem_addr <= {w_tag, w_idx};
            end
          end
        end
        S_WB: begin
          if (i_mem_rdy) begin
            r_state    <= S_FILL;
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b1;
            r_mem_addr <= {w_tag, w_idx};
          end
        end
        S_FILL: begin
          if (i_mem_rdy) begin
            r_state     <= S_INSTALL;
            r_mem_re    <= 1'b0;
            r_fill_line <= i_mem_rd_data;
          end
        end
        S_INSTALL: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase

      if (w_store_hit) r_dirty[w_idx] <= 1'b1;
      // Snoop invalidate beats a same-line store, but the install of a new line beats the snoop.
      if (w_snoop_kill) begin
        r_valid[w_sidx] <= 1'b0;
        r_dirty[w_sidx] <= 1'b0;
      end
      if (r_state == S_INSTALL) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_store_hit) begin
        r_data[w_idx][int'(w_off)*DATA_W +: DATA_W] <= i_wr_data;
      end else if (r_state == S_INSTALL) begin
        r_data[w_idx] <= r_fill_line;
        r_tag[w_idx]  <= w_tag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl_wb.sv
// Directed and random checks of dcache_ctrl_wb against a word-level reference memory,
// with a line-level backing memory answering the miss FSM.
module tb_dcache_ctrl_wb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [12:0] addr1, snoop_addr1;
  logic [15:0] wr_data1, rd_data1;
  logic we1, re1, hit1, stall1, mem_we1, mem_re1, mem_rdy1;
  logic snoop_req1, snoop_inv1, snoop_found1, snoop_dirty1;
  logic [10:0] mem_addr1;
  logic [63:0] mem_wr_data1, mem_rd_data1;
  logic [4:0]  tag_out1;
  logic [1:0]  state1;

  // OFFS_W=3, INDEX_W=4 instance
  logic [12:0] addr2, snoop_addr2;
  logic [15:0] wr_data2, rd_data2;
  logic we2, re2, hit2, stall2, mem_we2, mem_re2, mem_rdy2;
  logic snoop_req2, snoop_inv2, snoop_found2, snoop_dirty2;
  logic [9:0]   mem_addr2;
  logic [127:0] mem_wr_data2, mem_rd_data2;
  logic [5:0]   tag_out2;
  logic [1:0]   state2;

  dcache_ctrl_wb u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr1), .i_wr_data(wr_data1), .i_we(we1), .i_re(re1),
    .o_rd_data(rd_data1), .o_hit(hit1), .o_stall(stall1), .o_mem_addr(mem_addr1),
    .o_mem_wr_data(mem_wr_data1), .o_mem_we(mem_we1), .o_mem_re(mem_re1),
    .i_mem_rd_data(mem_rd_data1), .i_mem_rdy(mem_rdy1), .i_snoop_addr(snoop_addr1),
    .i_snoop_req(snoop_req1), .i_snoop_inv(snoop_inv1), .o_snoop_found(snoop_found1),
    .o_snoop_dirty(snoop_dirty1), .o_tag_out(tag_out1), .o_state(state1)
  );

  dcache_ctrl_wb #(.OFFS_W(3), .INDEX_W(4)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr2), .i_wr_data(wr_data2), .i_we(we2), .i_re(re2),
    .o_rd_data(rd_data2), .o_hit(hit2), .o_stall(stall2), .o_mem_addr(mem_addr2),
    .o_mem_wr_data(mem_wr_data2), .o_mem_we(mem_we2), .o_mem_re(mem_re2),
    .i_mem_rd_data(mem_rd_data2), .i_mem_rdy(mem_rdy2), .i_snoop_addr(snoop_addr2),
    .i_snoop_req(snoop_req2), .i_snoop_inv(snoop_inv2), .o_snoop_found(snoop_found2),
    .o_snoop_dirty(snoop_dirty2), .o_tag_out(tag_out2), .o_state(state2)
  );

  logic [15:0]  ref1 [8192];
  logic [63:0]  mem1 [2048];
  logic [15:0]  ref2 [8192];
  logic [127:0] mem2 [1024];
  logic [15:0]  exp_q [$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access1(input bit st, input logic [12:0] a, input logic [15:0] wd, input int dly,
                         output int lat, output bit f_hit, output bit f_stall, output bit wb_seen,
                         output logic [10:0] wb_addr, output logic [63:0] wb_data,
                         output logic [10:0] fill_addr, output bit unstable);
    int cnt;
    bit done;
    logic [15:0] e;
    lat = 0; cnt = 0; done = 0; wb_seen = 0; unstable = 0; f_hit = 0; f_stall = 0;
    wb_addr = '0; wb_data = '0; fill_addr = '0;
    @(negedge clk);
    addr1 = a; we1 = st; re1 = !st; wr_data1 = wd;
    if (!st) exp_q.push_back(ref1[a]);
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (c == 0) begin f_hit = hit1; f_stall = stall1; end
      if (hit1) done = 1;
      else begin
        lat++;
        if (mem_we1 && mem_re1) unstable = 1;
        if (mem_we1) begin
          if (!wb_seen) begin wb_seen = 1; wb_addr = mem_addr1; wb_data = mem_wr_data1; end
          else if (mem_addr1 !== wb_addr || mem_wr_data1 !== wb_data) unstable = 1;
        end
        if (mem_re1) begin
          if (cnt == 0) fill_addr = mem_addr1;
          else if (mem_addr1 !== fill_addr) unstable = 1;
        end
        if (mem_we1 || mem_re1) begin
          if (cnt == dly) begin
            mem_rdy1 = 1'b1; cnt = 0;
            if (mem_we1) mem1[mem_addr1] = mem_wr_data1;
            else mem_rd_data1 = mem1[mem_addr1];
          end else cnt++;
        end
        @(negedge clk);
        mem_rdy1 = 1'b0;
      end
    end
    if (!done) check("timeout1", 1'b0, 1'b1);
    if (!st) begin
      e = exp_q.pop_front();
      if (done) check("rd_data1", rd_data1, e);
    end else if (done) ref1[a] = wd;
    @(negedge clk);
    we1 = 1'b0; re1 = 1'b0;
  endtask

  task automatic access2(input bit st, input logic [12:0] a, input logic [15:0] wd, input int dly);
    int cnt;
    bit done;
    logic [15:0] e;
    cnt = 0; done = 0;
    @(negedge clk);
    addr2 = a; we2 = st; re2 = !st; wr_data2 = wd;
    if (!st) exp_q.push_back(ref2[a]);
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (hit2) done = 1;
      else begin
        if (mem_we2 || mem_re2) begin
          if (cnt == dly) begin
            mem_rdy2 = 1'b1; cnt = 0;
            if (mem_we2) mem2[mem_addr2] = mem_wr_data2;
            else mem_rd_data2 = mem2[mem_addr2];
          end else cnt++;
        end
        @(negedge clk);
        mem_rdy2 = 1'b0;
      end
    end
    if (!done) check("timeout2", 1'b0, 1'b1);
    if (!st) begin
      e = exp_q.pop_front();
      if (done) check("rd_data2", rd_data2, e);
    end else if (done) ref2[a] = wd;
    @(negedge clk);
    we2 = 1'b0; re2 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit fh, fs, wbs, uns;
    logic [10:0] wba, fa;
    logic [63:0] wbd, t1;
    logic [127:0] t2;

    for (int l = 0; l < 2048; l++) mem1[l] = {$urandom(), $urandom()};
    mem1[1] = 64'h4444_3333_2222_1111;
    for (int a = 0; a < 8192; a++) begin
      t1 = mem1[a >> 2];
      ref1[a] = t1[(a % 4) * 16 +: 16];
    end
    for (int l = 0; l < 1024; l++) mem2[l] = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int a = 0; a < 8192; a++) begin
      t2 = mem2[a >> 3];
      ref2[a] = t2[(a % 8) * 16 +: 16];
    end

    rst = 1'b1;
    addr1 = '0; wr_data1 = '0; we1 = 0; re1 = 0; mem_rdy1 = 0; mem_rd_data1 = '0;
    snoop_addr1 = '0; snoop_req1 = 0; snoop_inv1 = 0;
    addr2 = '0; wr_data2 = '0; we2 = 0; re2 = 0; mem_rdy2 = 0; mem_rd_data2 = '0;
    snoop_addr2 = '0; snoop_req2 = 0; snoop_inv2 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hit", hit1, 1'b0);
    check("rst_stall", stall1, 1'b0);
    check("rst_mem_we", mem_we1, 1'b0);
    check("rst_mem_re", mem_re1, 1'b0);
    check("rst_state", state1, 2'd0);

    // Cold load miss
    access1(0, 13'h004, 16'h0, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);
    check("cold_first_hit", fh, 1'b0);
    check("cold_first_stall", fs, 1'b1);
    check("cold_fill_addr", fa, 11'h001);
    check("cold_no_wb", wbs, 1'b0);
    check("cold_latency", lat, 3);

    // Store hit and neighbouring words
    access1(1, 13'h006, 16'hBEEF, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);
    check("st_hit", fh, 1'b1);
    check("st_stall", fs, 1'b0);
    access1(0, 13'h006, 16'h0, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);
    access1(0, 13'h005, 16'h0, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);
    check("ld_hit_latency", lat, 0);

    // we and re together act as a store
    @(negedge clk);
    addr1 = 13'h005; we1 = 1; re1 = 1; wr_data1 = 16'h5555;
    #1;
    check("wr_rd_hit", hit1, 1'b1);
    @(negedge clk);
    we1 = 0; re1 = 0; ref1[5] = 16'h5555;
    access1(0, 13'h005, 16'h0, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);

    // Dirty conflict with delayed mem_rdy
    access1(0, 13'h106, 16'h0, 5, lat, fh, fs, wbs, wba, wbd, fa, uns);
    check("dirty_wb_seen", wbs, 1'b1);
    check("dirty_wb_addr", wba, 11'h001);
    check("dirty_wb_data", wbd, {ref1[7], ref1[6], ref1[5], ref1[4]});
    check("dirty_fill_addr", fa, 11'h041);
    check("dirty_stable", uns, 1'b0);
    check("dirty_latency", lat, 14);
    access1(0, 13'h006, 16'h0, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);
    check("clean_evict_no_wb", wbs, 1'b0);

    // Snoop invalidate of a dirty line
    access1(1, 13'h007, 16'h7777, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);
    @(negedge clk);
    snoop_addr1 = 13'h104; snoop_req1 = 1; snoop_inv1 = 0;
    #1;
    check("snoop_miss_found", snoop_found1, 1'b0);
    snoop_addr1 = 13'h004; snoop_inv1 = 1;
    #1;
    check("snoop_found", snoop_found1, 1'b1);
    check("snoop_dirty", snoop_dirty1, 1'b1);
    @(negedge clk);
    snoop_req1 = 0; snoop_inv1 = 0;
    #1;
    check("snoop_after_inv", snoop_found1, 1'b0);
    mem1[1] = {ref1[7], ref1[6], ref1[5], ref1[4]};
    access1(0, 13'h004, 16'h0, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);
    check("post_snoop_no_wb", wbs, 1'b0);
    check("post_snoop_latency", lat, 3);

    // Reset during FILL
    @(negedge clk);
    addr1 = 13'h200; re1 = 1;
    @(negedge clk);
    #1;
    check("fill_mem_re", mem_re1, 1'b1);
    check("fill_state", state1, 2'd2);
    rst = 1'b1; re1 = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_fill_mem_re", mem_re1, 1'b0);
    check("rst_fill_stall", stall1, 1'b0);
    snoop_addr1 = 13'h004;
    #1;
    check("rst_invalid", snoop_found1, 1'b0);
    access1(0, 13'h005, 16'h0, 0, lat, fh, fs, wbs, wba, wbd, fa, uns);
    check("rst_reload_miss", fh, 1'b0);
    check("rst_reload_latency", lat, 3);

    // Random sweep on the OFFS_W=3, INDEX_W=4 instance
    for (int i = 0; i < 80; i++) begin
      access2(1'($urandom_range(0, 1)), 13'($urandom_range(0, 1023)),
              16'($urandom()), $urandom_range(0, 3));
    end
    for (int i = 0; i < 20; i++) begin
      access2(0, 13'($urandom_range(0, 1023)), 16'h0, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl_wb.md
Name: dcache_ctrl_wb

Overview:
Parametrised, direct-mapped, write-back data-cache controller for each core of the multicore processor. It sits between the DM stage and the shared memory port, and holds the tag, valid, dirty and data arrays internally.
- Hits on reads and writes complete in a single cycle.
- Misses stall the core while a miss FSM writes back a dirty victim and then fills the line.
- A snoop port reports and invalidates lines when another core searches this cache.

Parameters:
ADDR_W, 13, word-address width.
DATA_W, 16, CPU word width.
OFFS_W, 2, log2(words per line); a line is DATA_W<<OFFS_W bits wide (64 by default).
INDEX_W, 6, log2(number of lines).
TAG_W is derived, not overridable: ADDR_W-INDEX_W-OFFS_W (5 by default).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
addr  in  ADDR_W  CPU word address; fields are tag | index | offset
wr_data  in  DATA_W  CPU store data
we  in  1  store request
re  in  1  load request
rd_data  out  DATA_W  load data, valid when hit=1
hit  out  1  request hits in the current cycle
stall  out  1  miss in progress; CPU must hold addr/we/re/wr_data stable
mem_addr  out  ADDR_W-OFFS_W  line address sent to memory
mem_wr_data  out  DATA_W<<OFFS_W  victim line
mem_we  out  1  write-back request
mem_re  out  1  fill request
mem_rd_data  in  DATA_W<<OFFS_W  fill line
mem_rdy  in  1  one-cycle completion strobe for mem_we or mem_re
snoop_addr  in  ADDR_W  address searched by another core
snoop_req  in  1  snoop search
snoop_inv  in  1  invalidate on snoop hit; only meaningful with snoop_req
snoop_found  out  1  valid line with matching tag
snoop_dirty  out  1  found line is dirty
tag_out  out  TAG_W  tag stored at addr's index (victim tag)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - all valid and dirty bits are cleared; FSM goes to IDLE.
  - mem_we, mem_re, stall and hit are 0 in the cycle after reset.
  - Data and tag arrays are not reset.
  - Reset mid-miss abandons the transfer; mem_we and mem_re drop the next cycle.
- hit is combinational: (we|re) & valid[idx] & (tag[idx]==addr tag) & state==IDLE.
- rd_data is combinational: word[offset] of the line at idx. It is undefined when hit=0.
- Store hit: on the clk edge, word[offset] := wr_data and dirty[idx] := 1. The other words in the line are unchanged.
- we and re asserted together are treated as a store.
- stall = (we|re) & ~hit while in IDLE, and 1 in every other state.
- FSM:
  - IDLE to WB when there is a miss and the line at idx is valid and dirty.
  - IDLE to FILL when there is a miss and the line is clean or invalid.
  - WB: mem_we=1; mem_addr = {victim tag, idx}; mem_wr_data = victim line. These are held until mem_rdy, then go to FILL.
  - FILL: mem_re=1; mem_addr = {addr tag, idx}. Held until mem_rdy; mem_rd_data is captured on that edge. Go to INSTALL.
  - INSTALL (1 cycle): writes the captured line, the tag, valid=1 and dirty=0, then returns to IDLE. The held request then hits in IDLE, and a store sets dirty there.
- Miss latency (cycles with stall=1):
  - clean miss: 1 + Nfill + 1;
  - dirty miss: adds Nwb;
  - where Nfill and Nwb are cycles up to and including mem_rdy.
- mem_rdy outside WB or FILL is ignored. mem_we and mem_re are never both 1.
- Snoop:
  - snoop_found and snoop_dirty are combinational from snoop_addr in any state.
  - If snoop_inv & snoop_found, valid[sidx] := 0 and dirty[sidx] := 0 on the edge. Write-back responsibility passes to the requester.
  - If the snoop invalidates the same index the FSM is filling, INSTALL still proceeds, because the new line differs.
  - A snoop invalidate coinciding with a store hit to the same line: the invalidate wins and the store is lost. The CPU sees hit=1, but the interconnect must avoid this case.
- Offset selection wraps inside the line only; there is no cross-line access.

Test Plan:
- Reset, then re addr=0x004 → hit=0, stall=1, mem_re=1, mem_addr=0x001. After mem_rdy with line 0x4444_3333_2222_1111, INSTALL, then hit=1 and rd_data=0x1111.
- Store 0xBEEF to 0x006 on a resident line → hit=1, stall=0. A following load of 0x006 gives 0xBEEF, and a load of 0x005 keeps its old word.
- Dirty conflict: load 0x106, which has the same index and a different tag → mem_we=1 with victim line and mem_addr=0x001, then mem_re with mem_addr=0x041, then a hit. Delayed mem_rdy (5 cycles) must hold mem_we and mem_addr stable.
- Snoop 0x004 with snoop_inv while resident and dirty → snoop_found=1, snoop_dirty=1. The next CPU load misses without a write-back.
- Assert rst during FILL → the next cycle has mem_re=0 and stall=0, and all lines are invalid.
- Parameter sweep OFFS_W=3 and INDEX_W=4 → a random load/store sequence matches a reference memory model.
